// File: rtl/icache_direct_if.sv
// icache_direct_if: refill bus between the instruction cache and the memory
// IO controller. Level-held read request, single-cycle read acknowledge.
// The master side is the cache, the slave side is the memory IO controller.
interface icache_direct_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_rw;
  logic [2:0]            mem_len;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic                  mem_read_ok;
  logic [31:0]           mem_data;

  modport master (
    output mem_req, mem_rw, mem_len, mem_addr,
    input  mem_ready, mem_read_ok, mem_data
  );

  modport slave (
    input  mem_req, mem_rw, mem_len, mem_addr,
    output mem_ready, mem_read_ok, mem_data
  );
endinterface

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache. A hit returns one
// 32-bit word; a miss refills a 4-word line with four sequential 4-byte reads.
// flush invalidates every line; an in-flight refill read is allowed to finish
// and its data is discarded.
// Optional feature macro ICACHE_PERF_CNT_EN adds hit_cnt/miss_cnt outputs.
module icache_direct #(
  parameter int INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  inst_valid,
  output logic [31:0]           inst_out,
  icache_direct_if.master       mem
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 4;

  typedef enum logic [1:0] {IDLE, FILL, DONE, RESP} state_t;

  state_t                 state_q;
  logic [1:0]             w_q;
  logic [TAG_WIDTH-1:0]   miss_tag_q;
  logic [INDEX_WIDTH-1:0] miss_index_q;
  logic                   abort_q;
  logic                   mem_req_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [LINES-1:0]       valid_q;

  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [31:0]            data_mem [LINES][4];

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [1:0]             req_offset;
  logic                   hit;
  logic                   lookup;
  logic                   fill_write;
  logic                   unused_addr_bits;

  assign req_offset       = if_addr[3:2];
  assign req_index        = if_addr[INDEX_WIDTH+3:4];
  assign req_tag          = if_addr[ADDR_WIDTH-1:INDEX_WIDTH+4];
  assign unused_addr_bits = ^if_addr[1:0];

  assign hit    = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign lookup = (state_q == IDLE) && if_valid && !flush;

  // A refill beat is kept only when no flush is pending or arriving with it.
  assign fill_write = (state_q == FILL) && mem_req_q && mem.mem_read_ok &&
                      !abort_q && !flush;

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rw   = 1'b1;
  assign mem.mem_len  = 3'd2;

  // Line storage: data words and tags are not reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_write) begin
      data_mem[miss_index_q][w_q] <= mem.mem_data;
      if (w_q == 2'd3) begin
        tag_mem[miss_index_q] <= miss_tag_q;
      end
    end
  end

  // Control FSM: lookup, refill sequencing, flush abort and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      w_q          <= 2'd0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      abort_q      <= 1'b0;
      valid_q      <= '0;
      inst_valid   <= 1'b0;
      inst_out     <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      inst_valid <= 1'b0;
      if (flush) begin
        valid_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (lookup) begin
            if (hit) begin
              inst_out   <= data_mem[req_index][req_offset];
              inst_valid <= 1'b1;
              state_q    <= RESP;
            end else begin
              miss_tag_q   <= req_tag;
              miss_index_q <= req_index;
              w_q          <= 2'd0;
              abort_q      <= 1'b0;
              state_q      <= FILL;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        FILL: begin
          if (mem_req_q) begin
            if (mem.mem_read_ok) begin
              mem_req_q <= 1'b0;
              if (abort_q || flush) begin
                abort_q <= 1'b0;
                w_q     <= 2'd0;
                state_q <= IDLE;
              end else if (w_q == 2'd3) begin
                valid_q[miss_index_q] <= 1'b1;
                w_q                   <= 2'd0;
                state_q               <= DONE;
              end else begin
                w_q <= w_q + 2'd1;
              end
            end else if (flush) begin
              abort_q <= 1'b1;
            end
          end else if (flush) begin
            w_q     <= 2'd0;
            state_q <= IDLE;
          end else if (mem.mem_ready) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {miss_tag_q, miss_index_q, w_q, 2'b00};
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Performance counters: accepted lookups only, never cleared by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (lookup) begin
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
